// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and defaults for the program-counter generator
package pc_pkg;

    localparam int PC_XLEN_DEFAULT = 32;
    localparam int PC_STEP_DEFAULT = 4;

    typedef enum logic [1:0] {
        PC_BOOT,
        PC_RUN,
        PC_HALT
    } pc_state_e;

    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_SEQ,
        SRC_REDIRECT,
        SRC_TRAP,
        SRC_RAS,
        SRC_RESET
    } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; push when full overwrites the oldest entry
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             replace,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, top_ptr;
    logic [CNT_W-1:0] count_q, count_d;

    assign top_ptr  = wptr_q - PTR_W'(1);
    assign top_data = mem_q[top_ptr];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));

    // A replace on an empty stack still has to record the return address, so it degrades to a push.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (replace && !empty) begin
            mem_d[top_ptr] = push_data;
        end else if (push || replace) begin
            mem_d[wptr_q] = push_data;
            wptr_d        = wptr_q + PTR_W'(1);
            if (!full) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            wptr_d  = top_ptr;
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/sum_unit.sv
// rtl/sum_unit.sv - width-parametrised modulo adder used for the sequential PC step
module sum_unit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with stall/redirect/trap/halt; return-address stack under PC_RAS_EN
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = PC_XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              STEP         = PC_STEP_DEFAULT,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            call,
    input  logic            ret,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_valid,
    output logic            misaligned,
    output logic            ras_underflow
);

    localparam logic [XLEN-1:0] STEP_W     = XLEN'(STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            misaligned_q, misaligned_d;
    logic            ras_underflow_q, ras_underflow_d;
    logic [XLEN-1:0] pc_plus_step;
    logic            target_aligned;
    pc_src_e         pc_src;

    sum_unit #(.WIDTH(XLEN)) u_sum (
        .a   (pc_q),
        .b   (STEP_W),
        .sum (pc_plus_step)
    );

    assign target_aligned = ((redirect_target & ALIGN_MASK) == '0);

`ifdef PC_RAS_EN
    logic            ras_push, ras_pop, ras_replace, ras_empty;
    logic            unused_ras_full;
    logic [XLEN-1:0] ras_top;

    pc_ras #(.WIDTH(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .replace   (ras_replace),
        .push_data (pc_plus_step),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (unused_ras_full)
    );
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_ras;
    assign unused_ras = call | ret;
`endif

    always_comb begin
        state_d         = state_q;
        misaligned_d    = 1'b0;
        ras_underflow_d = 1'b0;
        pc_src          = SRC_HOLD;
`ifdef PC_RAS_EN
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_replace = 1'b0;
`endif
        unique case (state_q)
            PC_BOOT: begin
                pc_src  = SRC_RESET;
                state_d = PC_RUN;
            end
            PC_RUN: begin
                if (trap_valid) begin
                    pc_src = SRC_TRAP;
                end else if (redirect_valid) begin
                    if (target_aligned) begin
                        pc_src = SRC_REDIRECT;
`ifdef PC_RAS_EN
                        if (call && ret) begin
                            ras_replace = 1'b1;
                        end else if (call) begin
                            ras_push = 1'b1;
                        end
`endif
                    end else begin
                        misaligned_d = 1'b1;
                    end
                end else if (halt_req) begin
                    state_d = PC_HALT;
`ifdef PC_RAS_EN
                end else if (ret && !ras_empty) begin
                    pc_src  = SRC_RAS;
                    ras_pop = 1'b1;
                end else if (ret) begin
                    ras_underflow_d = 1'b1;
                    pc_src          = stall ? SRC_HOLD : SRC_SEQ;
`endif
                end else if (!stall) begin
                    pc_src = SRC_SEQ;
                end
            end
            PC_HALT: begin
                if (trap_valid) begin
                    pc_src  = SRC_TRAP;
                    state_d = PC_RUN;
                end else if (redirect_valid) begin
                    if (target_aligned) begin
                        pc_src  = SRC_REDIRECT;
                        state_d = PC_RUN;
                    end else begin
                        misaligned_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = PC_BOOT;
            end
        endcase

        pc_d = pc_q;
        unique case (pc_src)
            SRC_SEQ:      pc_d = pc_plus_step;
            SRC_REDIRECT: pc_d = redirect_target;
            SRC_TRAP:     pc_d = trap_vector;
            SRC_RESET:    pc_d = RESET_VECTOR;
`ifdef PC_RAS_EN
            SRC_RAS:      pc_d = ras_top;
`endif
            default:      pc_d = pc_q;
        endcase

        pc_valid_d = (state_d == PC_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= PC_BOOT;
            pc_q            <= RESET_VECTOR;
            pc_valid_q      <= 1'b0;
            misaligned_q    <= 1'b0;
            ras_underflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            pc_valid_q      <= pc_valid_d;
            misaligned_q    <= misaligned_d;
            ras_underflow_q <= ras_underflow_d;
        end
    end

    assign pc_out        = pc_q;
    assign pc_next       = pc_d;
    assign pc_valid      = pc_valid_q;
    assign misaligned    = misaligned_q;
    assign ras_underflow = ras_underflow_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen (STEP=4 and STEP=2 instances)
module tb_pc_gen;

`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, halt_req, rv, call, ret, tv;
    logic [31:0] rt, tvec;
    logic [31:0] pc_out, pc_next;
    logic        pc_valid, mis, uf;

    logic        r2v;
    logic [31:0] r2t;
    logic        zero = 1'b0;
    logic [31:0] zero_w = 32'h0;
    logic [31:0] pc2_out, pc2_next;
    logic        pc2_valid, mis2, uf2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h100), .STEP(4), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req),
        .redirect_valid(rv), .redirect_target(rt), .call(call), .ret(ret),
        .trap_valid(tv), .trap_vector(tvec), .pc_out(pc_out), .pc_next(pc_next),
        .pc_valid(pc_valid), .misaligned(mis), .ras_underflow(uf)
    );

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h100), .STEP(2), .RAS_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .stall(zero), .halt_req(zero),
        .redirect_valid(r2v), .redirect_target(r2t), .call(zero), .ret(zero),
        .trap_valid(zero), .trap_vector(zero_w), .pc_out(pc2_out), .pc_next(pc2_next),
        .pc_valid(pc2_valid), .misaligned(mis2), .ras_underflow(uf2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 0; halt_req = 0; rv = 0; call = 0; ret = 0; tv = 0;
        rt = 32'h0; tvec = 32'h0; r2v = 0; r2t = 32'h0;
        step();
        check("rst_pc", pc_out, 32'h100);
        check("rst_valid", {31'b0, pc_valid}, 32'd0);
        check("rst_mis", {31'b0, mis}, 32'd0);
        check("rst_uf", {31'b0, uf}, 32'd0);
        rst = 1'b0;
        #1;
        check("boot_valid", {31'b0, pc_valid}, 32'd0);
        check("boot_next", pc_next, 32'h100);
        step();
        check("first_pc", pc_out, 32'h100);
        check("first_valid", {31'b0, pc_valid}, 32'd1);
        check("first_next", pc_next, 32'h104);
        step();
        check("seq_104", pc_out, 32'h104);
        step();
        check("seq_108", pc_out, 32'h108);
        check("step2_pc", pc2_out, 32'h104);
        check("step2_valid", {31'b0, pc2_valid}, 32'd1);

        rv = 1; rt = 32'h10;
        #1;
        check("redir_next", pc_next, 32'h10);
        step();
        check("redir_pc", pc_out, 32'h10);
        rv = 0; stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", pc_out, 32'h10);
        end
        rv = 1; rt = 32'h40;
        step();
        check("stall_redir", pc_out, 32'h40);
        stall = 0; rt = 32'h60; tv = 1; tvec = 32'h80;
        step();
        check("trap_prio", pc_out, 32'h80);
        rv = 0; tv = 0;

        rv = 1; rt = 32'h22; r2v = 1; r2t = 32'h22;
        #1;
        check("mis_next", pc_next, 32'h80);
        check("step2_next", pc2_next, 32'h22);
        step();
        check("mis_hold", pc_out, 32'h80);
        check("mis_pulse", {31'b0, mis}, 32'd1);
        check("step2_accept", pc2_out, 32'h22);
        check("step2_nomis", {31'b0, mis2}, 32'd0);
        rv = 0; r2v = 0;
        step();
        check("mis_clear", {31'b0, mis}, 32'd0);
        check("mis_seq", pc_out, 32'h84);

        rv = 1; rt = 32'h20;
        step();
        check("ras_pre", pc_out, 32'h20);
        call = 1; rt = 32'h200;
        step();
        check("call1", pc_out, 32'h200);
        rv = 0; call = 0;
        step();
        check("call1_seq", pc_out, 32'h204);
        rv = 1; call = 1; rt = 32'h300;
        step();
        check("call2", pc_out, 32'h300);
        rv = 0; call = 0; ret = 1;
        step();
        check("ret1", pc_out, RAS ? 32'h208 : 32'h304);
        step();
        check("ret2", pc_out, RAS ? 32'h24 : 32'h308);
        check("ret2_uf", {31'b0, uf}, 32'd0);
        step();
        check("ret_empty", pc_out, RAS ? 32'h28 : 32'h30C);
        check("ret_empty_uf", {31'b0, uf}, {31'b0, RAS});
        ret = 0;
        step();
        check("uf_clear", {31'b0, uf}, 32'd0);
        check("uf_seq", pc_out, RAS ? 32'h2C : 32'h310);

`ifdef PC_RAS_EN
        for (int i = 0; i < 5; i++) begin
            rv = 1; call = 1; rt = 32'h1000 + 32'(i) * 32'h100;
            step();
            check("ovf_call", pc_out, 32'h1000 + 32'(i) * 32'h100);
        end
        rv = 0; call = 0; ret = 1;
        step(); check("ovf_ret1", pc_out, 32'h1304);
        step(); check("ovf_ret2", pc_out, 32'h1204);
        step(); check("ovf_ret3", pc_out, 32'h1104);
        step(); check("ovf_ret4", pc_out, 32'h1004);
        step();
        check("ovf_empty", pc_out, 32'h1008);
        check("ovf_uf", {31'b0, uf}, 32'd1);
        ret = 0; rv = 1; call = 1; rt = 32'h2000;
        step();
        ret = 1; rt = 32'h3000;
        step();
        check("repl_pc", pc_out, 32'h3000);
        rv = 0; call = 0;
        step();
        check("repl_ret", pc_out, 32'h2004);
        step();
        check("repl_empty_uf", {31'b0, uf}, 32'd1);
        ret = 0;
`endif

        rv = 1; rt = 32'h50;
        step();
        check("halt_pre", pc_out, 32'h50);
        rv = 0; halt_req = 1;
        #1;
        check("halt_next", pc_next, 32'h50);
        step();
        check("halt_pc", pc_out, 32'h50);
        check("halt_valid", {31'b0, pc_valid}, 32'd0);
        stall = 1; ret = 1;
        step();
        check("halt_frozen", pc_out, 32'h50);
        check("halt_uf", {31'b0, uf}, 32'd0);
        stall = 0; ret = 0; halt_req = 0;
        step();
        check("halt_stay", {31'b0, pc_valid}, 32'd0);
        rv = 1; rt = 32'h90;
        step();
        check("halt_exit_pc", pc_out, 32'h90);
        check("halt_exit_valid", {31'b0, pc_valid}, 32'd1);
        rt = 32'hFFFF_FFFC;
        step();
        check("wrap_pre", pc_out, 32'hFFFF_FFFC);
        rv = 0;
        #1;
        check("wrap_next", pc_next, 32'h0);
        step();
        check("wrap_pc", pc_out, 32'h0);

        rv = 1; call = 1; rt = 32'h500;
        step();
        check("ar_call", pc_out, 32'h500);
        rv = 0; call = 0; halt_req = 1;
        step();
        check("ar_halt", {31'b0, pc_valid}, 32'd0);
        halt_req = 0;
        #3 rst = 1'b1;
        #1;
        check("ar_pc", pc_out, 32'h100);
        check("ar_valid", {31'b0, pc_valid}, 32'd0);
        #2 rst = 1'b0;
        step();
        check("ar_restart", pc_out, 32'h100);
        check("ar_restart_valid", {31'b0, pc_valid}, 32'd1);
        ret = 1;
        step();
        check("ar_ret_pc", pc_out, 32'h104);
        check("ar_ret_uf", {31'b0, uf}, {31'b0, RAS});
        ret = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the single-cycle/pipelined RV32 core; successor to the fixed +4 counter. Produces the fetch address each cycle with stall, branch/jump redirect, trap vectoring, halt, alignment checking and an optional return-address stack. Sits between the control/branch unit and the instruction memory address port.

## Interface
- XLEN, 32, address width in bits
- RESET_VECTOR, 0, pc_out value after reset
- STEP, 4, increment per sequential fetch (4, or 2 for compressed fetch)
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2; used only with PC_RAS_EN)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold current PC
- halt_req  in  1  enter HALT
- redirect_valid  in  1  branch/jump taken
- redirect_target  in  XLEN  branch/jump destination
- call  in  1  qualifies redirect as call (push pc_out+STEP)
- ret  in  1  return: next PC from RAS top
- trap_valid  in  1  exception/interrupt taken
- trap_vector  in  XLEN  trap handler address
- pc_out  out  XLEN  current fetch address (registered)
- pc_next  out  XLEN  combinational next-PC value
- pc_valid  out  1  pc_out is a valid fetch address
- misaligned  out  1  registered one-cycle pulse: rejected target
- ras_underflow  out  1  registered one-cycle pulse: ret on empty RAS

## Operation
- FSM states: BOOT, RUN, HALT.
- BOOT: entered on reset; pc_valid=0, PC held at RESET_VECTOR; unconditionally to RUN next edge.
- RUN: pc_valid=1. Next-PC priority: trap_valid > redirect_valid > ret > stall > pc_out+STEP.
- Trap: PC←trap_vector; RAS untouched.
- Redirect: target checked against STEP alignment (low bits of log2(STEP) must be zero). Misaligned → PC held, misaligned pulses, no RAS push. Aligned → PC←target; with call, push pc_out+STEP.
- ret (no trap/redirect): RAS non-empty → PC←top, pop; empty → PC←pc_out+STEP (or held if stall), ras_underflow pulses.
- call and ret both with aligned redirect: redirect target wins; top entry replaced by pc_out+STEP, count unchanged.
- Redirect and trap override stall.
- halt_req in RUN (no trap/redirect same cycle) → HALT. HALT: pc_valid=0, PC frozen; trap_valid or aligned redirect_valid loads PC and returns to RUN; halt_req/stall/ret ignored.
- Arithmetic: pc_out+STEP modulo 2^XLEN; 0xFFFFFFFC+4 wraps to 0.
- RAS: circular, count saturates at RAS_DEPTH; push when full overwrites oldest entry.

## Timing
- Reset values: pc_out=RESET_VECTOR, pc_valid=0, misaligned=0, ras_underflow=0, RAS count=0, state BOOT.
- Reset mid-operation: all of above immediately, asynchronously; RAS contents discarded.
- All state updates on rising clk; pc_next reflects next-edge value same cycle (zero latency, combinational from inputs).
- Redirect/trap asserted in cycle N → pc_out=target in cycle N+1.
- First valid fetch: first rising edge after rst deasserts moves BOOT→RUN; pc_out=RESET_VECTOR with pc_valid=1 for that cycle; increments from the following edge.
- misaligned/ras_underflow high exactly one cycle after the offending input.

## Configuration
- PC_RAS_EN defined: RAS present as described.
- Undefined: no RAS storage; call ignored; ret treated as no-op (sequential/stall behaviour); ras_underflow tied 0.

## Structure
- Shared package pc_pkg: FSM state enum (PC_BOOT, PC_RUN, PC_HALT), next-PC source enum, default XLEN/STEP constants.
- One sub-module: pc_ras (parametrised circular stack with push, pop, replace, empty, full) instantiated only under PC_RAS_EN.
- Adder is the existing sum_unit, widened to XLEN.

## Test plan
- Reset: rst high then low, RESET_VECTOR=0x100 → pc_valid=0 in BOOT, then 0x100 valid one cycle, then 0x104, 0x108.
- Stall/priority: stall held 3 cycles at 0x10 → pc_out stays 0x10; stall+redirect 0x40 → 0x40 next cycle; redirect+trap(0x80) → 0x80.
- Misalign: redirect to 0x22, STEP=4 → pc_out held, misaligned pulses one cycle; STEP=2 → accepted.
- RAS: call at 0x20 to 0x200, call at 0x204 to 0x300, ret, ret → 0x208, then 0x24; fifth push at RAS_DEPTH=4 overwrites oldest; ret on empty → ras_underflow pulse, sequential PC.
- Halt: halt_req at 0x50 → pc_valid=0, pc frozen 0x50; redirect 0x90 → RUN, pc_out=0x90; wrap 0xFFFFFFFC → 0x0.
- Async reset asserted mid-RAS/HALT → immediate RESET_VECTOR, pc_valid=0, empty RAS on restart.
